// File: rtl/dac_spi_driver_if.sv
// rtl/dac_spi_driver_if.sv - sample-in / DAC-pin bundle for dac_spi_driver
//
// Purpose: groups the sample handshake and the DAC pin outputs of
// dac_spi_driver into one interface.
// Signals:
//   i_data_in  [9:0]  sample, offset binary
//   i_load            one-cycle strobe, i_data_in valid in that cycle
//   o_dac_cs_n        SPI chip select, active low
//   o_dac_sck         SPI clock, idles low
//   o_dac_sdi         SPI data, MSB first
//   o_dac_ld_n        DAC latch strobe, active low
//   o_busy            frame in progress
//   o_overrun         sticky, load seen while busy
// Modports: slave = the driver, master = the sample source / observer.
interface dac_spi_driver_if;
   logic [9:0] i_data_in;
   logic       i_load;
   logic       o_dac_cs_n;
   logic       o_dac_sck;
   logic       o_dac_sdi;
   logic       o_dac_ld_n;
   logic       o_busy;
   logic       o_overrun;

   modport slave (
      input  i_data_in, i_load,
      output o_dac_cs_n, o_dac_sck, o_dac_sdi, o_dac_ld_n, o_busy, o_overrun
   );

   modport master (
      output i_data_in, i_load,
      input  o_dac_cs_n, o_dac_sck, o_dac_sdi, o_dac_ld_n, o_busy, o_overrun
   );
endinterface

// File: rtl/dac_spi_driver.sv
// rtl/dac_spi_driver.sv - 16-bit SPI write frame plus latch pulse for an MCP4911-class DAC
//
// Purpose: on a load strobe, serialises {0, BUF, GA_n, SHDN_n, data[9:0], 00}
// MSB first in SPI mode 0,0, waits one divide period with cs_n high, then
// pulses ld_n low for one divide period.
// Ports:
//   i_sysclk  system clock, rising edge
//   i_reset   asynchronous, active-high reset
//   bus       dac_spi_driver_if.slave (sample in, DAC pins and status out)
// Parameters:
//   CLK_DIV     sysclk cycles per SCK half-period (>= 1)
//   BUF_BIT     frame BUF bit
//   GA_N_BIT    frame GA_n bit
//   SHDN_N_BIT  frame SHDN_n bit
module dac_spi_driver #(
   parameter int   CLK_DIV    = 25,
   parameter logic BUF_BIT    = 1'b0,
   parameter logic GA_N_BIT   = 1'b1,
   parameter logic SHDN_N_BIT = 1'b1
) (
   input logic              i_sysclk,
   input logic              i_reset,
   dac_spi_driver_if.slave  bus
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] DIV_TC = CW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_GAP   = 2'd2,
      S_LATCH = 2'd3
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_div_cnt;
   logic [3:0]    r_bit_cnt;
   logic [15:0]   r_shift;
   logic          r_cs_n;
   logic          r_sck;
   logic          r_sdi;
   logic          r_ld_n;
   logic          r_busy;
   logic          r_overrun;

   logic          w_div_tc;
   logic [15:0]   w_frame;

   assign w_div_tc = (r_div_cnt == DIV_TC);
   assign w_frame  = {1'b0, BUF_BIT, GA_N_BIT, SHDN_N_BIT, bus.i_data_in, 2'b00};

   always_ff @(posedge i_sysclk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_cs_n    <= 1'b1;
         r_sck     <= 1'b0;
         r_sdi     <= 1'b0;
         r_ld_n    <= 1'b1;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         // A load outside IDLE never disturbs the frame; it is only recorded.
         if (bus.i_load && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (bus.i_load) begin
                  r_shift   <= w_frame;
                  r_sdi     <= w_frame[15];
                  r_cs_n    <= 1'b0;
                  r_div_cnt <= '0;
                  r_bit_cnt <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               if (w_div_tc) begin
                  r_div_cnt <= '0;
                  r_sck     <= ~r_sck;
                  // r_sck high here means this toggle is a falling edge:
                  // the DAC has already sampled the current bit.
                  if (r_sck) begin
                     if (r_bit_cnt == 4'd15) begin
                        r_cs_n  <= 1'b1;
                        r_sdi   <= 1'b0;
                        r_state <= S_GAP;
                     end else begin
                        r_shift   <= {r_shift[14:0], 1'b0};
                        r_sdi     <= r_shift[14];
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end

            S_GAP: begin
               if (w_div_tc) begin
                  r_div_cnt <= '0;
                  r_ld_n    <= 1'b0;
                  r_state   <= S_LATCH;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end

            S_LATCH: begin
               if (w_div_tc) begin
                  r_div_cnt <= '0;
                  r_ld_n    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_dac_cs_n = r_cs_n;
   assign bus.o_dac_sck  = r_sck;
   assign bus.o_dac_sdi  = r_sdi;
   assign bus.o_dac_ld_n = r_ld_n;
   assign bus.o_busy     = r_busy;
   assign bus.o_overrun  = r_overrun;

endmodule

// File: tb/tb_dac_spi_driver.sv
// tb/tb_dac_spi_driver.sv - randomized self-checking bench for dac_spi_driver
module tb_dac_spi_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // Per-instance configuration: 0 = defaults, 1 = CLK_DIV 1, 2 = inverted frame bits
   int div_p [3] = '{25, 1, 25};
   int buf_p [3] = '{0, 0, 1};
   int ga_p  [3] = '{1, 1, 0};
   int sh_p  [3] = '{1, 1, 0};

   logic [9:0] din [3] = '{10'h0, 10'h0, 10'h0};
   logic [2:0] ld = 3'b000;

   dac_spi_driver_if if0 ();
   dac_spi_driver_if if1 ();
   dac_spi_driver_if if2 ();

   assign if0.i_data_in = din[0];
   assign if1.i_data_in = din[1];
   assign if2.i_data_in = din[2];
   assign if0.i_load    = ld[0];
   assign if1.i_load    = ld[1];
   assign if2.i_load    = ld[2];

   wire [2:0] cs_n_v = {if2.o_dac_cs_n, if1.o_dac_cs_n, if0.o_dac_cs_n};
   wire [2:0] sck_v  = {if2.o_dac_sck,  if1.o_dac_sck,  if0.o_dac_sck};
   wire [2:0] sdi_v  = {if2.o_dac_sdi,  if1.o_dac_sdi,  if0.o_dac_sdi};
   wire [2:0] ldn_v  = {if2.o_dac_ld_n, if1.o_dac_ld_n, if0.o_dac_ld_n};
   wire [2:0] busy_v = {if2.o_busy,     if1.o_busy,     if0.o_busy};
   wire [2:0] ovr_v  = {if2.o_overrun,  if1.o_overrun,  if0.o_overrun};

   dac_spi_driver #(.CLK_DIV(25)) u_dut0 (.i_sysclk(clk), .i_reset(rst), .bus(if0));
   dac_spi_driver #(.CLK_DIV(1))  u_dut1 (.i_sysclk(clk), .i_reset(rst), .bus(if1));
   dac_spi_driver #(.CLK_DIV(25), .BUF_BIT(1'b1), .GA_N_BIT(1'b0), .SHDN_N_BIT(1'b0))
      u_dut2 (.i_sysclk(clk), .i_reset(rst), .bus(if2));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference frame built from the bit-field layout with plain arithmetic.
   function automatic logic [15:0] exp_frame(input int i, input logic [9:0] d);
      int v;
      v = buf_p[i] * 16384 + ga_p[i] * 8192 + sh_p[i] * 4096 + int'(d) * 4;
      return v[15:0];
   endfunction

   // Bus observer: per frame, bits captured on SCK rising edges and the
   // length in cycles of busy, cs_n low, cs_n-high gap and ld_n low.
   int          frames_done [3] = '{0, 0, 0};
   int          stray_ld    [3] = '{0, 0, 0};
   logic [15:0] rx          [3] = '{16'h0, 16'h0, 16'h0};
   int          nbits       [3] = '{0, 0, 0};
   int          busy_cnt    [3] = '{0, 0, 0};
   int          cs_cnt      [3] = '{0, 0, 0};
   int          ld_cnt      [3] = '{0, 0, 0};
   int          gap_cnt     [3] = '{0, 0, 0};
   logic [15:0] last_rx     [3] = '{16'h0, 16'h0, 16'h0};
   int          last_nbits  [3] = '{0, 0, 0};
   int          last_busy   [3] = '{0, 0, 0};
   int          last_cs     [3] = '{0, 0, 0};
   int          last_ld     [3] = '{0, 0, 0};
   int          last_gap    [3] = '{0, 0, 0};
   logic [2:0]  p_sck  = 3'b000;
   logic [2:0]  p_busy = 3'b000;

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (busy_v[i] && !p_busy[i]) begin
            busy_cnt[i] <= 1;
            cs_cnt[i]   <= cs_n_v[i] ? 0 : 1;
            ld_cnt[i]   <= 0;
            gap_cnt[i]  <= 0;
            nbits[i]    <= 0;
            rx[i]       <= 16'h0;
         end else begin
            if (busy_v[i]) busy_cnt[i] <= busy_cnt[i] + 1;
            if (!cs_n_v[i]) cs_cnt[i] <= cs_cnt[i] + 1;
            if (!ldn_v[i]) begin
               if (busy_v[i]) ld_cnt[i] <= ld_cnt[i] + 1;
               else stray_ld[i] <= stray_ld[i] + 1;
            end
            if (busy_v[i] && cs_n_v[i] && ldn_v[i]) gap_cnt[i] <= gap_cnt[i] + 1;
            if (sck_v[i] && !p_sck[i]) begin
               rx[i]    <= {rx[i][14:0], sdi_v[i]};
               nbits[i] <= nbits[i] + 1;
            end
         end
         if (!busy_v[i] && p_busy[i]) begin
            frames_done[i] <= frames_done[i] + 1;
            last_rx[i]     <= rx[i];
            last_nbits[i]  <= nbits[i];
            last_busy[i]   <= busy_cnt[i];
            last_cs[i]     <= cs_cnt[i];
            last_ld[i]     <= ld_cnt[i];
            last_gap[i]    <= gap_cnt[i];
         end
      end
      p_sck  <= sck_v;
      p_busy <= busy_v;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse(input int i, input logic [9:0] d);
      din[i] = d;
      ld[i]  = 1'b1;
      step();
      ld[i]  = 1'b0;
   endtask

   task automatic wait_done(input int i, input int f0, input string tag);
      int k;
      k = 0;
      while (frames_done[i] == f0 && k < 34 * div_p[i] + 50) begin
         step();
         k++;
      end
      if (frames_done[i] == f0) chk({tag, "_timeout"}, 0, 1);
   endtask

   task automatic check_frame(input int i, input logic [9:0] d, input string tag);
      chk({tag, "_frame"}, last_rx[i], exp_frame(i, d));
      chk({tag, "_nbits"}, last_nbits[i], 16);
      chk({tag, "_busy"},  last_busy[i], 34 * div_p[i]);
      chk({tag, "_cs"},    last_cs[i], 32 * div_p[i]);
      chk({tag, "_gap"},   last_gap[i], div_p[i]);
      chk({tag, "_ld"},    last_ld[i], div_p[i]);
   endtask

   task automatic run_frame(input int i, input logic [9:0] d, input string tag);
      int f0;
      f0 = frames_done[i];
      pulse(i, d);
      wait_done(i, f0, tag);
      check_frame(i, d, tag);
   endtask

   task automatic check_idle(input int i, input string tag);
      chk({tag, "_cs_n"}, cs_n_v[i], 1);
      chk({tag, "_sck"},  sck_v[i], 0);
      chk({tag, "_sdi"},  sdi_v[i], 0);
      chk({tag, "_ld_n"}, ldn_v[i], 1);
      chk({tag, "_busy"}, busy_v[i], 0);
      chk({tag, "_ovr"},  ovr_v[i], 0);
   endtask

   initial begin
      logic [9:0] d1;
      int f0;
      int sck_hi;
      int busy_hi;

      repeat (3) step();
      for (int i = 0; i < 3; i++) check_idle(i, $sformatf("rst%0d", i));
      rst = 1'b0;
      step();

      // Defaults, fixed sample
      run_frame(0, 10'h3A5, "dflt_3a5");

      // Second load mid-frame is ignored but flagged
      d1 = 10'($urandom);
      f0 = frames_done[0];
      pulse(0, d1);
      repeat (99) step();
      chk("ovr_pre", ovr_v[0], 0);
      pulse(0, ~d1);
      chk("ovr_set", ovr_v[0], 1);
      wait_done(0, f0, "ovr_frame");
      check_frame(0, d1, "ovr_frame");
      run_frame(0, 10'($urandom), "ovr_next");
      chk("ovr_sticky", ovr_v[0], 1);

      // Reset 300 cycles into a frame aborts it
      pulse(0, 10'($urandom));
      repeat (299) step();
      rst = 1'b1;
      #1;
      check_idle(0, "abort");
      repeat (3) step();
      rst = 1'b0;
      sck_hi  = 0;
      busy_hi = 0;
      repeat (100) begin
         step();
         sck_hi  += int'(sck_v[0]);
         busy_hi += int'(busy_v[0]);
      end
      chk("abort_sck_quiet", sck_hi, 0);
      chk("abort_busy_quiet", busy_hi, 0);
      chk("abort_no_ld", last_ld[0], 0);
      run_frame(0, 10'($urandom), "post_abort");

      // Reset and load together: load is lost
      rst   = 1'b1;
      din[0] = 10'($urandom);
      ld[0] = 1'b1;
      step();
      rst   = 1'b0;
      ld[0] = 1'b0;
      busy_hi = 0;
      repeat (60) begin
         step();
         busy_hi += int'(busy_v[0]);
      end
      chk("rst_load_busy", busy_hi, 0);
      chk("rst_load_cs", cs_n_v[0], 1);

      // CLK_DIV = 1, back-to-back frames
      run_frame(1, 10'h000, "d1_000");
      run_frame(1, 10'h3FF, "d1_3ff");
      for (int n = 0; n < 6; n++) run_frame(1, 10'($urandom), $sformatf("d1_rnd%0d", n));
      chk("d1_no_ovr", ovr_v[1], 0);

      // Alternate frame control bits
      run_frame(2, 10'h155, "bits_155");
      run_frame(2, 10'($urandom), "bits_rnd");

      for (int i = 0; i < 3; i++) chk($sformatf("stray_ld%0d", i), stray_ld[i], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
